// File: rtl/uart_mem_loader.sv
// Parses SYNC/LEN_HI/LEN_LO/data frames from the UART byte stream and writes little-endian words to memory.
// Optional trailing XOR checksum byte enabled by defining UART_LOADER_CHECKSUM_EN.
module uart_mem_loader #(
  parameter int unsigned CLK_FREQ       = 100_000_000,
  parameter int unsigned ADDR_WIDTH     = 10,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = CLK_FREQ / 100
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [31:0]           mem_wdata,
  output logic                  busy,
  output logic                  done,
  output logic                  error
);

  localparam int unsigned TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [31:0] MAX_WORDS = 32'd1 << ADDR_WIDTH;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LEN_HI,
    S_LEN_LO,
    S_DATA
`ifdef UART_LOADER_CHECKSUM_EN
    , S_CHECK
`endif
  } state_t;

  state_t                state, state_n;
  logic [15:0]           len, len_n;
  logic [15:0]           word_cnt, word_cnt_n;
  logic [1:0]            byte_idx, byte_idx_n;
  logic [TW-1:0]         tmo_cnt, tmo_n;
  logic [ADDR_WIDTH-1:0] addr_n;
  logic [31:0]           wdata_n;
  logic                  we_n, busy_n, done_n, error_n;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]            csum, csum_n;
`endif

  // State and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      len       <= '0;
      word_cnt  <= '0;
      byte_idx  <= '0;
      tmo_cnt   <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      error     <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      csum      <= '0;
`endif
    end else begin
      state     <= state_n;
      len       <= len_n;
      word_cnt  <= word_cnt_n;
      byte_idx  <= byte_idx_n;
      tmo_cnt   <= tmo_n;
      mem_we    <= we_n;
      mem_addr  <= addr_n;
      mem_wdata <= wdata_n;
      busy      <= busy_n;
      done      <= done_n;
      error     <= error_n;
`ifdef UART_LOADER_CHECKSUM_EN
      csum      <= csum_n;
`endif
    end
  end

  // Frame parser; the address advances after each write strobe, independent of state
  always_comb begin
    state_n    = state;
    len_n      = len;
    word_cnt_n = word_cnt;
    byte_idx_n = byte_idx;
    tmo_n      = tmo_cnt;
    addr_n     = mem_we ? mem_addr + ADDR_WIDTH'(1) : mem_addr;
    wdata_n    = mem_wdata;
    we_n       = 1'b0;
    busy_n     = busy;
    done_n     = done;
    error_n    = error;
`ifdef UART_LOADER_CHECKSUM_EN
    csum_n     = csum;
`endif

    if (state != S_IDLE) tmo_n = rx_valid ? '0 : tmo_cnt + TW'(1);

    unique case (state)
      S_IDLE: begin
        if (rx_valid && rx_data == SYNC_BYTE) begin
          state_n    = S_LEN_HI;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          error_n    = 1'b0;
          addr_n     = '0;
          byte_idx_n = '0;
          word_cnt_n = '0;
          tmo_n      = '0;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_n     = '0;
`endif
        end
      end
      S_LEN_HI: begin
        if (rx_valid) begin
          len_n[15:8] = rx_data;
          state_n     = S_LEN_LO;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_n      = csum ^ rx_data;
`endif
        end
      end
      S_LEN_LO: begin
        if (rx_valid) begin
          len_n[7:0] = rx_data;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_n     = csum ^ rx_data;
`endif
          if (32'(len_n) > MAX_WORDS) begin
            error_n = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
          end else if (len_n == 16'd0) begin
`ifdef UART_LOADER_CHECKSUM_EN
            state_n = S_CHECK;
`else
            done_n  = 1'b1;
            busy_n  = 1'b0;
            state_n = S_IDLE;
`endif
          end else begin
            state_n = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (rx_valid) begin
          wdata_n[{byte_idx, 3'b000} +: 8] = rx_data;
          byte_idx_n = byte_idx + 2'd1;
`ifdef UART_LOADER_CHECKSUM_EN
          csum_n     = csum ^ rx_data;
`endif
          if (byte_idx == 2'd3) begin
            we_n       = 1'b1;
            word_cnt_n = word_cnt + 16'd1;
            if (word_cnt == len - 16'd1) begin
`ifdef UART_LOADER_CHECKSUM_EN
              state_n = S_CHECK;
`else
              done_n  = 1'b1;
              busy_n  = 1'b0;
              state_n = S_IDLE;
`endif
            end
          end
        end
      end
`ifdef UART_LOADER_CHECKSUM_EN
      S_CHECK: begin
        if (rx_valid) begin
          done_n  = (rx_data == csum);
          error_n = (rx_data != csum);
          busy_n  = 1'b0;
          state_n = S_IDLE;
        end
      end
`endif
      default: state_n = S_IDLE;
    endcase

    // Inter-byte silence inside a frame aborts it; already written words stay
    if (state != S_IDLE && !rx_valid && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
      error_n = 1'b1;
      busy_n  = 1'b0;
      state_n = S_IDLE;
    end
  end

endmodule

// File: tb/tb_uart_mem_loader.sv
// Directed bench for uart_mem_loader; define UART_LOADER_CHECKSUM_EN for both bench and RTL to test the checksum build.
module tb_uart_mem_loader;

  localparam int unsigned AW  = 10;
  localparam int unsigned TMO = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic [7:0]    rx_data;
  logic          rx_valid;
  logic          mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic          busy, done, error;

  int checks = 0;
  int errors = 0;

  logic [AW-1:0] wr_addr[$];
  logic [31:0]   wr_data[$];
  logic [7:0]    fb[$];

  uart_mem_loader #(
    .CLK_FREQ(100_000_000), .ADDR_WIDTH(AW), .SYNC_BYTE(8'hA5), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .busy(busy), .done(done), .error(error)
  );

  always #5 clk = ~clk;

  // Write log sampled mid-cycle; a stuck strobe shows up as extra entries
  always @(negedge clk) begin
    if (mem_we) begin
      wr_addr.push_back(mem_addr);
      wr_data.push_back(mem_wdata);
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  // All stimulus tasks start and end 1 time unit after a rising edge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic send_frame(input bit corrupt);
    logic [7:0] x;
    x = 8'h00;
    for (int i = 0; i < fb.size(); i++) begin
      send_byte(fb[i]);
      if (i > 0) x = x ^ fb[i];
    end
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(corrupt ? ~x : x);
`else
    if (corrupt) x = ~x;
`endif
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;
    idle(3);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_err", 64'(error), 64'd0);
    check("rst_we", 64'(mem_we), 64'd0);
    check("rst_addr", 64'(mem_addr), 64'd0);
    check("rst_wdata", 64'(mem_wdata), 64'd0);
    rst = 1'b0;
    idle(2);

    // Single word frame; strobe appears the cycle after the 4th data byte
    clear_log();
    fb = '{8'hA5, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    foreach (fb[i]) send_byte(fb[i]);
    check("a_we", 64'(mem_we), 64'd1);
    check("a_addr", 64'(mem_addr), 64'd0);
    check("a_wdata", 64'(mem_wdata), 64'h12345678);
`ifdef UART_LOADER_CHECKSUM_EN
    send_byte(8'h09);
`else
    idle(1);
`endif
    check("a_addr_inc", 64'(mem_addr), 64'd1);
    idle(2);
    check("a_nwr", 64'(wr_addr.size()), 64'd1);
    check("a_done", 64'(done), 64'd1);
    check("a_busy", 64'(busy), 64'd0);
    check("a_err", 64'(error), 64'd0);

    // Three words back-to-back
    clear_log();
    fb = '{8'hA5, 8'h00, 8'h03, 8'h01, 8'h00, 8'h00, 8'h00, 8'h02, 8'h00, 8'h00, 8'h00,
           8'h03, 8'h00, 8'h00, 8'h00};
    send_frame(1'b0);
    idle(3);
    check("b_nwr", 64'(wr_addr.size()), 64'd3);
    for (int i = 0; i < 3; i++) begin
      if (i < wr_addr.size()) begin
        check("b_addr", 64'(wr_addr[i]), 64'(i));
        check("b_data", 64'(wr_data[i]), 64'(i + 1));
      end
    end
    check("b_done", 64'(done), 64'd1);

    // Sync byte value inside the frame is plain data
    clear_log();
    fb = '{8'hA5, 8'h00, 8'h01, 8'hA5, 8'hA5, 8'hA5, 8'hA5};
    send_frame(1'b0);
    idle(3);
    check("s_nwr", 64'(wr_addr.size()), 64'd1);
    if (wr_data.size() > 0) check("s_data", 64'(wr_data[0]), 64'hA5A5A5A5);
    check("s_done", 64'(done), 64'd1);

    // Zero-length frame
    clear_log();
    fb = '{8'hA5, 8'h00, 8'h00};
    send_frame(1'b0);
    idle(2);
    check("z_done", 64'(done), 64'd1);
    check("z_nwr", 64'(wr_addr.size()), 64'd0);

    // Truncated frame then silence
    clear_log();
    foreach (fb[i]) fb[i] = 8'h00;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h11); send_byte(8'h22);
    idle(50);
    check("t_busy_hold", 64'(busy), 64'd1);
    check("t_done_clr", 64'(done), 64'd0);
    idle(20);
    check("t_err", 64'(error), 64'd1);
    check("t_busy", 64'(busy), 64'd0);
    check("t_nwr", 64'(wr_addr.size()), 64'd0);

    // Length 1025 rejected right after LEN_LO
    clear_log();
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h01);
    check("l_err", 64'(error), 64'd1);
    check("l_busy", 64'(busy), 64'd0);
    idle(3);
    check("l_nwr", 64'(wr_addr.size()), 64'd0);

    // Length 1024 is the largest accepted
    send_byte(8'hA5); send_byte(8'h04); send_byte(8'h00);
    check("m_busy", 64'(busy), 64'd1);
    check("m_err", 64'(error), 64'd0);
    idle(TMO + 5);
    check("m_tmo_err", 64'(error), 64'd1);

`ifdef UART_LOADER_CHECKSUM_EN
    // Wrong checksum: word still written, frame flagged bad
    clear_log();
    fb = '{8'hA5, 8'h00, 8'h01, 8'h78, 8'h56, 8'h34, 8'h12};
    send_frame(1'b1);
    idle(2);
    check("c_nwr", 64'(wr_addr.size()), 64'd1);
    check("c_err", 64'(error), 64'd1);
    check("c_done", 64'(done), 64'd0);
`endif

    // Reset after 5 data bytes of a 2-word frame
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_byte(8'h01); send_byte(8'h02); send_byte(8'h03); send_byte(8'h04);
    send_byte(8'h05);
    rst = 1'b1;
    idle(1);
    check("r_busy", 64'(busy), 64'd0);
    check("r_we", 64'(mem_we), 64'd0);
    check("r_addr", 64'(mem_addr), 64'd0);
    check("r_wdata", 64'(mem_wdata), 64'd0);
    check("r_err", 64'(error), 64'd0);
    rst = 1'b0;
    idle(1);
    clear_log();
    fb = '{8'hA5, 8'h00, 8'h01, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    send_frame(1'b0);
    idle(3);
    check("r2_nwr", 64'(wr_addr.size()), 64'd1);
    if (wr_addr.size() > 0) begin
      check("r2_addr", 64'(wr_addr[0]), 64'd0);
      check("r2_data", 64'(wr_data[0]), 64'hDEADBEEF);
    end
    check("r2_done", 64'(done), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_mem_loader.md
Name: uart_mem_loader

Overview:
Downstream consumer of the UART receive stage. Takes the received byte stream (one-cycle valid strobes), parses a simple load frame, assembles little-endian 32-bit words and writes them to instruction/data memory at consecutive word addresses. Used to download programs into SimpleCPU over the serial link without resynthesis.

Parameters:
CLK_FREQ, 100_000_000, system clock frequency in Hz
ADDR_WIDTH, 10, memory word-address width; max frame length 2^ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker
TIMEOUT_CYCLES, CLK_FREQ/100, max idle cycles between bytes inside a frame (10 ms)

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
rx_data  input  8  byte from UART receiver
rx_valid  input  1  one-cycle strobe; rx_data valid this cycle
mem_we  output  1  one-cycle memory write strobe
mem_addr  output  ADDR_WIDTH  word address for write
mem_wdata  output  32  word to write
busy  output  1  frame in progress; CPU held in reset by top level while high
done  output  1  last frame completed successfully (level)
error  output  1  last frame aborted (level)

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high. All state updates on posedge clk.
- Reset: state IDLE, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, error=0, all counters 0.
- Frame: SYNC_BYTE, LEN_HI, LEN_LO (16-bit word count N, big-endian), 4*N data bytes, [checksum byte, see optional feature].
- States: IDLE -> LEN_HI -> LEN_LO -> DATA -> (CHECK) -> IDLE.
- IDLE: rx_valid with rx_data==SYNC_BYTE -> LEN_HI, busy=1, done=0, error=0, mem_addr=0, byte index=0. Other bytes ignored; done/error hold.
- LEN_HI: store byte as N[15:8]. LEN_LO: store N[7:0]. If N > 2^ADDR_WIDTH -> error=1, busy=0, IDLE. If N==0 -> CHECK (macro on) or finish (macro off).
- DATA: byte index 0..3 loads mem_wdata[7:0],[15:8],[23:16],[31:24]. The cycle after the 4th byte is accepted: mem_we=1 for exactly one cycle with mem_addr = current word address; mem_addr increments the cycle after the strobe. After word N is written -> CHECK or finish.
- mem_addr/mem_wdata stable while mem_we high. Wrap: with N==2^ADDR_WIDTH, mem_addr wraps to 0 after final write; no further writes occur.
- Finish: busy=0, done=1, IDLE.
- Timeout: in any non-IDLE state a counter clears on rx_valid and increments otherwise; at TIMEOUT_CYCLES -> error=1, busy=0, IDLE. Words already written are not rolled back.
- SYNC_BYTE inside a frame is treated as data (no resync).
- rx_valid in the same cycle as mem_we: byte accepted normally (back-to-back bytes must never be lost).
- rst mid-frame: immediate return to reset values; no pending mem_we issued.

Optional Feature:
UART_LOADER_CHECKSUM_EN
- Defined: after the last data byte a checksum byte is expected in CHECK; checksum is the XOR of LEN_HI, LEN_LO and all data bytes. Match -> done=1; mismatch -> error=1. Both return to IDLE with busy=0.
- Not defined: no CHECK state; the frame finishes after the last word write (or after LEN_LO when N==0). Any byte following the frame is parsed in IDLE.

Test Plan:
- Reset, then frame A5 00 01 78 56 34 12 [+ checksum 0x09 if macro on] -> single mem_we with mem_addr=0, mem_wdata=0x12345678; done=1, busy=0.
- Frame N=3 with words 0x00000001, 0x00000002, 0x00000003, bytes sent back-to-back -> three mem_we pulses at addr 0,1,2 with matching data; done=1.
- Frame A5 00 01 then only 2 data bytes, then silence > TIMEOUT_CYCLES -> error=1, busy=0, no mem_we.
- Length A5 04 01 with ADDR_WIDTH=10 (N=1025) -> error=1 immediately after LEN_LO, no writes.
- Macro on: valid frame with wrong checksum byte -> word written, then error=1, done=0.
- Assert rst after 5 data bytes of a 2-word frame -> all outputs at reset values next cycle; a following valid frame completes with done=1 starting at mem_addr=0.
